// File: rtl/ult_pkg.sv
// Shared types and helpers for the multi-channel ultrasonic ranger.
//   state_t        : ranging FSM states
//   ZONE_*         : distance-zone codes presented on the zone outputs
//   zone_classify  : maps an echo width onto a zone code (unsigned compare)
// Optional feature macro used by the top: ULT_AVG2_EN (two-sample averaging).
package ult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        DONE,
        HOLDOFF
    } state_t;

    localparam logic [1:0] ZONE_NONE = 2'b00;
    localparam logic [1:0] ZONE_NEAR = 2'b01;
    localparam logic [1:0] ZONE_MID  = 2'b10;
    localparam logic [1:0] ZONE_FAR  = 2'b11;

    function automatic logic [1:0] zone_classify(input logic [31:0] w,
                                                 input logic [31:0] near_cyc,
                                                 input logic [31:0] far_cyc);
        if (w < near_cyc)
            return ZONE_NEAR;
        else if (w < far_cyc)
            return ZONE_MID;
        else
            return ZONE_FAR;
    endfunction

endpackage

// File: rtl/ult_ranger_multi_if.sv
// Sensor-side bundle of the ultrasonic ranger.
//   enable   : run round-robin while high
//   echo     : raw echo inputs, one per channel
//   trig     : trigger outputs, at most one high
//   width    : last echo width per channel, channel k at [k*CNT_W +: CNT_W]
//   zone     : zone code per channel, channel k at [2*k +: 2]
//   timeout  : per-channel timeout flag
//   valid    : one-cycle pulse when a channel result updates
//   valid_ch : channel index belonging to valid
// master = controller/driver side, slave = ranger side.
interface ult_ranger_multi_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 21
);
    logic                    enable;
    logic [N_CH-1:0]         echo;
    logic [N_CH-1:0]         trig;
    logic [N_CH*CNT_W-1:0]   width;
    logic [N_CH*2-1:0]       zone;
    logic [N_CH-1:0]         timeout;
    logic                    valid;
    logic [2:0]              valid_ch;

    modport master (
        output enable, echo,
        input  trig, width, zone, timeout, valid, valid_ch
    );

    modport slave (
        input  enable, echo,
        output trig, width, zone, timeout, valid, valid_ch
    );
endinterface

// File: rtl/ult_echo_sync.sv
// Echo input conditioner: 2-flop synchroniser followed by an edge-detect
// register. rise/fall are single-cycle pulses derived from the synchronised
// level, so an edge on echo_raw is acted upon 3 clocks later.
//   clock, reset_n : system clock, async active-low reset
//   echo_raw       : asynchronous echo input
//   echo_lvl       : synchronised echo level
//   rise, fall     : edge pulses of echo_lvl
module ult_echo_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic echo_raw,
    output logic echo_lvl,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= echo_raw;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign echo_lvl = s2;
    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
endmodule

// File: rtl/ult_ranger_multi.sv
// Round-robin ranging controller for N_CH HC-SR04 class sensors. Each channel
// gets a trigger pulse, a timed echo measurement with timeout, and a stored
// echo width plus distance-zone code.
//   clock, reset_n : system clock, async active-low reset
//   bus (slave)    : enable/echo in; trig/width/zone/timeout/valid/valid_ch out
// Optional macro ULT_AVG2_EN: good results are averaged with the previous
// stored width of the channel (first result after reset/timeout is stored raw).
//
// state     | meaning
// IDLE      | parked, waiting for enable
// TRIG      | trig[ch] high for TRIG_CYC cycles
// WAIT_ECHO | waiting for echo rising edge, bounded by TIMEOUT_CYC
// MEASURE   | counting echo high cycles, bounded by TIMEOUT_CYC
// DONE      | commit result of channel ch
// HOLDOFF   | quiet time, then advance to next channel
module ult_ranger_multi #(
    parameter int N_CH        = 2,
    parameter int CNT_W       = 21,
    parameter int TRIG_CYC    = 500,
    parameter int TIMEOUT_CYC = 1_500_000,
    parameter int HOLDOFF_CYC = 3_000_000,
    parameter int NEAR_CYC    = 29_000,
    parameter int FAR_CYC     = 87_000
) (
    input logic           clock,
    input logic           reset_n,
    ult_ranger_multi_if.slave bus
);
    import ult_pkg::*;

    // Trigger and holdoff share one down-counter; holdoff can exceed CNT_W.
    localparam int TMR_MAX = (HOLDOFF_CYC > TRIG_CYC) ? HOLDOFF_CYC : TRIG_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [2:0] LAST_CH = 3'(N_CH - 1);

    state_t               state, next_state;
    logic [2:0]           ch;
    logic [CNT_W-1:0]     cnt;
    logic [TMR_W-1:0]     tmr;
    logic                 meas_to;
    logic                 cnt_tc, tmr_tc;

    logic [N_CH-1:0]      e_lvl, e_rise, e_fall;
    logic                 sel_lvl, sel_rise, sel_fall;

    logic [CNT_W-1:0]     width_r [N_CH];
    logic [1:0]           zone_r  [N_CH];
    logic [N_CH-1:0]      timeout_r;
    logic                 valid_r;
    logic [2:0]           valid_ch_r;
    logic [CNT_W-1:0]     new_w;
    logic [N_CH-1:0]      trig_c;
    logic [N_CH*CNT_W-1:0] width_p;
    logic [N_CH*2-1:0]    zone_p;

    for (genvar k = 0; k < N_CH; k++) begin : g_sync
        ult_echo_sync u_sync (
            .clock    (clock),
            .reset_n  (reset_n),
            .echo_raw (bus.echo[k]),
            .echo_lvl (e_lvl[k]),
            .rise     (e_rise[k]),
            .fall     (e_fall[k])
        );
    end

    always_comb begin
        sel_lvl  = 1'b0;
        sel_rise = 1'b0;
        sel_fall = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch == 3'(k)) begin
                sel_lvl  = e_lvl[k];
                sel_rise = e_rise[k];
                sel_fall = e_fall[k];
            end
        end
    end

    assign cnt_tc = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign tmr_tc = (tmr == '0);

`ifdef ULT_AVG2_EN
    logic [N_CH-1:0]  primed;
    logic [CNT_W-1:0] old_w;
    logic             prim_sel;
    logic [CNT_W:0]   avg_sum;

    always_comb begin
        old_w    = '0;
        prim_sel = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch == 3'(k)) begin
                old_w    = width_r[k];
                prim_sel = primed[k];
            end
        end
        avg_sum = {1'b0, old_w} + {1'b0, cnt};
        new_w   = prim_sel ? avg_sum[CNT_W:1] : cnt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            primed <= '0;
        end else if (state == DONE) begin
            for (int k = 0; k < N_CH; k++)
                if (ch == 3'(k)) primed[k] <= !meas_to;
        end
    end
`else
    assign new_w = cnt;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (bus.enable) next_state = TRIG;
            TRIG:      if (tmr_tc) next_state = WAIT_ECHO;
            WAIT_ECHO: begin
                if (sel_rise)    next_state = MEASURE;
                else if (cnt_tc) next_state = DONE;
            end
            MEASURE:   if (sel_fall || cnt_tc) next_state = DONE;
            DONE:      next_state = HOLDOFF;
            HOLDOFF:   if (tmr_tc) next_state = bus.enable ? TRIG : IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Combinational from the state register so reset drops trig at once.
    always_comb begin
        trig_c = '0;
        for (int k = 0; k < N_CH; k++)
            trig_c[k] = (state == TRIG) && (ch == 3'(k));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ch         <= '0;
            cnt        <= '0;
            tmr        <= '0;
            meas_to    <= 1'b0;
            timeout_r  <= '0;
            valid_r    <= 1'b0;
            valid_ch_r <= '0;
            for (int k = 0; k < N_CH; k++) begin
                width_r[k] <= '0;
                zone_r[k]  <= ZONE_NONE;
            end
        end else begin
            valid_r <= (state == DONE);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.enable) tmr <= TMR_W'(TRIG_CYC - 1);
                end
                TRIG: begin
                    if (tmr_tc) cnt <= '0;
                    else        tmr <= tmr - TMR_W'(1);
                end
                WAIT_ECHO: begin
                    // The rise cycle is already the first high cycle of echo_lvl.
                    if (sel_rise) begin
                        cnt     <= CNT_W'(1);
                        meas_to <= 1'b0;
                    end else if (cnt_tc) begin
                        meas_to <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (sel_fall)
                        meas_to <= 1'b0;
                    else if (cnt_tc)
                        meas_to <= 1'b1;
                    else if (sel_lvl && cnt != '1)
                        cnt <= cnt + CNT_W'(1);
                end
                DONE: begin
                    valid_ch_r <= ch;
                    for (int k = 0; k < N_CH; k++) begin
                        if (ch == 3'(k)) begin
                            if (meas_to) begin
                                zone_r[k]    <= ZONE_NONE;
                                timeout_r[k] <= 1'b1;
                            end else begin
                                width_r[k]   <= new_w;
                                zone_r[k]    <= zone_classify(32'(new_w), 32'(NEAR_CYC), 32'(FAR_CYC));
                                timeout_r[k] <= 1'b0;
                            end
                        end
                    end
                    cnt <= '0;
                    tmr <= TMR_W'(HOLDOFF_CYC - 1);
                end
                HOLDOFF: begin
                    if (tmr_tc) begin
                        ch <= (ch == LAST_CH) ? 3'd0 : ch + 3'd1;
                        if (bus.enable) tmr <= TMR_W'(TRIG_CYC - 1);
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        width_p = '0;
        zone_p  = '0;
        for (int k = 0; k < N_CH; k++) begin
            width_p[k*CNT_W +: CNT_W] = width_r[k];
            zone_p[2*k +: 2]          = zone_r[k];
        end
    end

    assign bus.trig     = trig_c;
    assign bus.width    = width_p;
    assign bus.zone     = zone_p;
    assign bus.timeout  = timeout_r;
    assign bus.valid    = valid_r;
    assign bus.valid_ch = valid_ch_r;
endmodule

// File: tb/tb_ult_ranger_multi.sv
module tb_ult_ranger_multi;
    localparam int N_CH = 2, CNT_W = 21, TRIG_CYC = 10, TIMEOUT_CYC = 1000;
    localparam int HOLDOFF_CYC = 50, NEAR_CYC = 200, FAR_CYC = 600;
    localparam int WB = N_CH * CNT_W, ZB = N_CH * 2;
`ifdef ULT_AVG2_EN
    localparam int AVG = 1;
`else
    localparam int AVG = 0;
`endif

    logic clock = 1'b0, reset_n = 1'b0;
    always #5 clock = ~clock;

    ult_ranger_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    ult_ranger_multi #(
        .N_CH(N_CH), .CNT_W(CNT_W), .TRIG_CYC(TRIG_CYC), .TIMEOUT_CYC(TIMEOUT_CYC),
        .HOLDOFF_CYC(HOLDOFF_CYC), .NEAR_CYC(NEAR_CYC), .FAR_CYC(FAR_CYC)
    ) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    typedef struct { int len; int exp_w; int exp_z; int exp_to; } vec_t;
    typedef struct { logic [2:0] ch; logic [WB-1:0] width; logic [ZB-1:0] zone;
                     logic [N_CH-1:0] to; int cyc; } res_t;
    typedef struct { logic [N_CH-1:0] pat; int len; int rise; } tev_t;

    int checks = 0, errors = 0;
    int cyc = 0, trun = 0, trise = 0, last_valid_cyc = -1, exp_ch = 0;
    logic [N_CH-1:0] tpat;
    logic [WB+ZB+N_CH-1:0] prev_out;
    res_t valid_q[$];
    tev_t trig_q[$];

    // reference model: per-channel stored result
    int mw[N_CH], mz[N_CH];
    bit mto[N_CH], mprimed[N_CH];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got no event expected one within bound", nm);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            mw[k] = 0; mz[k] = 0; mto[k] = 0; mprimed[k] = 0;
        end
    endtask

    task automatic model_apply(input int c, input int len);
        int nw;
        if (len == 0 || len >= TIMEOUT_CYC) begin
            mto[c] = 1; mz[c] = 0; mprimed[c] = 0;
        end else begin
            nw = len;
            if (AVG != 0 && mprimed[c]) nw = (mw[c] + len) / 2;
            mw[c] = nw;
            mz[c] = (nw < NEAR_CYC) ? 1 : (nw < FAR_CYC) ? 2 : 3;
            mto[c] = 0; mprimed[c] = 1;
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            trun = 0;
        end else begin
            if (bus.trig != '0) begin
                if (trun == 0) begin tpat = bus.trig; trise = cyc; end
                else if (bus.trig != tpat) tpat = '1;
                trun++;
                chk("trig_onehot", 64'($countones(bus.trig)), 64'd1);
            end else if (trun > 0) begin
                trig_q.push_back('{tpat, trun, trise});
                trun = 0;
            end
            if (bus.valid)
                valid_q.push_back('{bus.valid_ch, bus.width, bus.zone, bus.timeout, cyc});
            else
                chk("stable_outputs", 64'({bus.width, bus.zone, bus.timeout}), 64'(prev_out));
        end
        prev_out = {bus.width, bus.zone, bus.timeout};
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_trig"}, 64'(bus.trig), 64'd0);
        chk({tag, "_width"}, 64'(bus.width), 64'd0);
        chk({tag, "_zone"}, 64'(bus.zone), 64'd0);
        chk({tag, "_timeout"}, 64'(bus.timeout), 64'd0);
        chk({tag, "_valid"}, 64'(bus.valid), 64'd0);
        chk({tag, "_valid_ch"}, 64'(bus.valid_ch), 64'd0);
    endtask

    task automatic after_reset();
        trig_q.delete();
        valid_q.delete();
        model_reset();
        exp_ch = 0;
        last_valid_cyc = -1;
    endtask

    function automatic logic [N_CH-1:0] onehot(input int c);
        logic [N_CH-1:0] p;
        p = '0;
        p[c] = 1'b1;
        return p;
    endfunction

    task automatic wait_trig(output tev_t te, output bit ok);
        int c = 0;
        while (trig_q.size() == 0 && c < 3000) begin @(negedge clock); c++; end
        ok = (trig_q.size() != 0);
        if (!ok) begin fail("trig_wait"); return; end
        te = trig_q.pop_front();
        chk("trig_sel", 64'(te.pat), 64'(onehot(exp_ch)));
        chk("trig_len", 64'(te.len), 64'(TRIG_CYC));
        if (last_valid_cyc >= 0)
            chk("holdoff_gap", 64'(te.rise - last_valid_cyc), 64'(HOLDOFF_CYC));
    endtask

    // len = 0: echo never rises. drop_at >= 0: enable cleared at that echo cycle.
    task automatic run_meas(input int len, input int drop_at, output res_t r);
        tev_t te;
        bit ok;
        int c;
        logic [WB-1:0] ew;
        logic [ZB-1:0] ez;
        logic [N_CH-1:0] et;
        r = '{3'd7, '0, '0, '0, 0};
        wait_trig(te, ok);
        if (!ok) return;
        repeat (3) @(negedge clock);
        if (len > 0) begin
            bus.echo[exp_ch] = 1'b1;
            for (int i = 0; i < len; i++) begin
                if (i == drop_at) bus.enable = 1'b0;
                @(negedge clock);
            end
            bus.echo[exp_ch] = 1'b0;
        end
        c = 0;
        while (valid_q.size() == 0 && c < 3000) begin @(negedge clock); c++; end
        if (valid_q.size() == 0) begin fail("valid_wait"); return; end
        r = valid_q.pop_front();
        model_apply(exp_ch, len);
        for (int k = 0; k < N_CH; k++) begin
            ew[k*CNT_W +: CNT_W] = CNT_W'(mw[k]);
            ez[2*k +: 2] = 2'(mz[k]);
            et[k] = mto[k];
        end
        chk("valid_ch", 64'(r.ch), 64'(exp_ch));
        chk("model_width", 64'(r.width), 64'(ew));
        chk("model_zone", 64'(r.zone), 64'(ez));
        chk("model_timeout", 64'(r.to), 64'(et));
        last_valid_cyc = r.cyc;
        exp_ch = (exp_ch + 1) % N_CH;
    endtask

    vec_t tbl[12];
    res_t r;
    tev_t te;
    bit ok;
    int c, len;

    initial begin
        #900_000;
        $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ULT_AVG2_EN
        tbl[0] = '{150, 150, 1, 0};  tbl[1]  = '{0, 0, 0, 1};
        tbl[2] = '{400, 275, 2, 0};  tbl[3]  = '{1, 1, 1, 0};
        tbl[4] = '{800, 537, 2, 0};  tbl[5]  = '{199, 100, 1, 0};
        tbl[6] = '{1100, 537, 0, 1}; tbl[7]  = '{200, 150, 1, 0};
        tbl[8] = '{300, 300, 2, 0};  tbl[9]  = '{599, 374, 2, 0};
        tbl[10] = '{600, 450, 2, 0}; tbl[11] = '{0, 374, 0, 1};
`else
        tbl[0] = '{150, 150, 1, 0};  tbl[1]  = '{0, 0, 0, 1};
        tbl[2] = '{400, 400, 2, 0};  tbl[3]  = '{1, 1, 1, 0};
        tbl[4] = '{800, 800, 3, 0};  tbl[5]  = '{199, 199, 1, 0};
        tbl[6] = '{1100, 800, 0, 1}; tbl[7]  = '{200, 200, 2, 0};
        tbl[8] = '{300, 300, 2, 0};  tbl[9]  = '{599, 599, 2, 0};
        tbl[10] = '{600, 600, 3, 0}; tbl[11] = '{0, 599, 0, 1};
`endif
        bus.enable = 1'b0;
        bus.echo = '0;
        model_reset();
        repeat (5) @(negedge clock);
        #1 check_reset_vals("por");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        chk("idle_no_trig", 64'(trig_q.size()), 64'd0);
        bus.enable = 1'b1;

        for (int i = 0; i < 12; i++) begin
            c = exp_ch;
            run_meas(tbl[i].len, -1, r);
            chk("tbl_width", 64'(r.width[c*CNT_W +: CNT_W]), 64'(tbl[i].exp_w));
            chk("tbl_zone", 64'(r.zone[2*c +: 2]), 64'(tbl[i].exp_z));
            chk("tbl_timeout", 64'(r.to[c]), 64'(tbl[i].exp_to));
        end

        for (int i = 0; i < 16; i++) begin
            c = $urandom_range(0, 9);
            if (c < 2)       len = 0;
            else if (c == 2) len = $urandom_range(1040, 1150);
            else             len = $urandom_range(1, 900);
            run_meas(len, -1, r);
        end

        // reset while a trigger pulse is high
        c = 0;
        while (bus.trig == '0 && c < 3000) begin @(negedge clock); c++; end
        if (bus.trig == '0) fail("trig_before_reset");
        repeat (4) @(negedge clock);
        chk("trig_pre_rst", 64'(bus.trig), 64'(onehot(exp_ch)));
        reset_n = 1'b0;
        #1 check_reset_vals("rst_trig");
        repeat (3) @(negedge clock);
        after_reset();
        reset_n = 1'b1;
        run_meas(100, -1, r);

        // reset while channel 1 is measuring an echo
        wait_trig(te, ok);
        repeat (3) @(negedge clock);
        bus.echo[exp_ch] = 1'b1;
        repeat (20) @(negedge clock);
        reset_n = 1'b0;
        #1 check_reset_vals("rst_meas");
        bus.echo = '0;
        repeat (3) @(negedge clock);
        after_reset();
        reset_n = 1'b1;

        run_meas(100, -1, r);
        chk("first_w0", 64'(r.width[CNT_W-1:0]), 64'd100);
        run_meas(50, -1, r);
        run_meas(300, -1, r);
        chk("avg_w0", 64'(r.width[CNT_W-1:0]), (AVG != 0) ? 64'd200 : 64'd300);
        chk("avg_z0", 64'(r.zone[1:0]), 64'd2);

        // enable cleared during MEASURE of channel 1
        run_meas(100, 50, r);
        chk("drop_valid_ch", 64'(r.ch), 64'd1);
        repeat (200) @(negedge clock);
        chk("parked_no_trig_ev", 64'(trig_q.size()), 64'd0);
        chk("parked_trig", 64'(bus.trig), 64'd0);
        bus.enable = 1'b1;
        last_valid_cyc = -1;
        run_meas(250, -1, r);
        chk("resume_z0", 64'(r.zone[1:0]), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
